mem_io_responder: RTL and testbench
===================================

Name: mem_io_responder

Overview:
- Memory-side responder for the single-cycle `mips` core. It answers the core's data-port requests: `mem_wr`, `mem_addr`, `mem_writedata` in; `mem_readdata` out.
- Decodes `mem_addr` into a word-addressed data RAM and four memory-mapped I/O registers:
  - keyboard receive FIFO data
  - keyboard receive FIFO status
  - LED register
  - free-running cycle counter
- Reads are combinational within the same cycle, as the single-cycle core requires. All state changes happen on the rising clock edge.

Parameters:
- Dbits, 32, data word width (RAM word, register width, `mem_readdata` width).
- Nloc, 64, data RAM depth in words; power of two.
- Fdepth, 8, keyboard FIFO depth in entries; power of two, at least 2.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- enable  input  1  core enable; when low, no writes, pops or counter increments occur
- mem_wr  input  1  write strobe from core, sampled at the rising edge
- mem_addr  input  32  byte address from core
- mem_writedata  input  Dbits  store data
- mem_readdata  output  Dbits  combinational read data
- key_valid  input  1  keyboard character present this cycle
- key_data  input  8  keyboard character
- key_ready  output  1  FIFO not full
- leds  output  16  LED register, low 16 bits

Behaviour:
- Region decode uses `mem_addr[31:28]`:
  - 4'h1: data RAM, word index `mem_addr[2 +: log2(Nloc)]`.
  - 4'h2: I/O, register select `mem_addr[3:2]`.
  - Any other value: reads return 0, writes are ignored.
  - `mem_addr[1:0]` is ignored everywhere.
- Effective write: `mem_wr & enable`.
- RAM behaviour:
  - Read is asynchronous.
  - Write lands at the clock edge, so the new value is readable the following cycle.
  - RAM contents are not reset.
- I/O offset 0, KEYDATA:
  - Read returns {zeros, head entry}; returns 0 when the FIFO is empty.
  - A write pops the head entry; the data written is ignored.
  - A pop while empty is a no-op.
- I/O offset 1, KEYSTAT:
  - Read returns bit31 = not empty, bit30 = sticky overflow, bits[log2(Fdepth):0] = entry count, all other bits 0.
  - Any write clears the overflow bit.
- I/O offset 2, LED: read/write register; `leds = LED[15:0]`.
- I/O offset 3, CYCLES:
  - Increments by 1 every clock edge while `enable` is high.
  - Wraps from 2^Dbits-1 to 0.
  - A write loads 0; this takes priority over the increment in the same cycle.
- FIFO push and pop:
  - Push occurs when `key_valid` is high and (not full, or a pop happens in the same cycle).
  - Push is independent of `enable`.
  - Push and pop in the same cycle: count is unchanged, pointers both advance, and order is preserved.
  - Push into a full FIFO with no simultaneous pop: the character is dropped and overflow is set to 1.
  - `key_ready` is the registered not-full state; it does not account for a pop in the same cycle.
  - Read and write pointers are log2(Fdepth) bits and wrap modulo Fdepth. Count is tracked separately to tell full from empty.
- Reset (asynchronous) clears:
  - FIFO count and both pointers to 0
  - overflow to 0
  - LED to 0, so `leds` = 0
  - CYCLES to 0
  - `key_ready` = 1
  - During reset, `mem_readdata` reflects the cleared register values (KEYDATA reads 0).
  - Reset mid-stream discards all queued characters.
- Latency:
  - Reads: 0 cycles (combinational).
  - Writes and pops: visible on the next cycle.

Decomposition:
- Package `memio_pkg` holds:
  - region codes (RAM_REGION = 4'h1, IO_REGION = 4'h2)
  - I/O offset constants KEYDATA = 0, KEYSTAT = 1, LED = 2, CYCLES = 3
  - KEYSTAT bit positions
- One sub-module, `key_fifo`, parameterised by depth and width. It carries `clk`, `reset`, push, pop, data in and out, count, full and empty.
- Decode, RAM, LED, counter and the read mux stay in the top module.

Test Plan:
- Reset, then store 0xDEADBEEF to 0x10000008 with `enable`=1, then load 0x10000008 -> `mem_readdata` = 0xDEADBEEF the next cycle. Load 0x10000004 -> unchanged. Load 0x30000000 -> 0.
- Push 'A' (0x41) then 'B' (0x42), then read 0x20000004 -> 0x80000002. Read 0x20000000 -> 0x41. Write 0x20000000, then read -> 0x42.
- Push 9 characters into Fdepth=8 with no pops -> `key_ready` = 0 after the 8th push. KEYSTAT = 0xC0000008. The 9th character is dropped. Write KEYSTAT -> 0x80000008.
- With the FIFO full, assert `key_valid` with 0x55 and pop in the same cycle -> count stays 8, no overflow, 0x55 is the last entry out after 8 pops, and `key_ready` tracks the count.
- Hold `enable` high for 10 cycles -> CYCLES reads 10. Write CYCLES -> next read 1. Drop `enable` -> the value holds and an LED write with `enable`=0 is ignored.
- Write 0x0001ABCD to 0x20000008 -> `leds` = 0xABCD. Assert `reset` mid-cycle with 3 entries queued -> `leds`, count and CYCLES go to 0 immediately, and `key_ready` = 1.

Source files
------------

// File: rtl/mem_io_responder_pkg.sv
// Shared constants for the memory/I-O responder.
// This file holds the address-region codes, the I/O register offsets and the KEYSTAT bit layout.
package memio_pkg;

    localparam logic [3:0] RAM_REGION = 4'h1;
    localparam logic [3:0] IO_REGION  = 4'h2;

    typedef enum logic [1:0] {
        KEYDATA = 2'd0,
        KEYSTAT = 2'd1,
        LED     = 2'd2,
        CYCLES  = 2'd3
    } io_reg_e;

    localparam int KS_NEMPTY_BIT = 31;
    localparam int KS_OVF_BIT    = 30;

endpackage

// File: rtl/mem_io_responder_if.sv
// Data-port bus between the single-cycle core (master) and the memory responder (slave).
interface mem_io_if #(
    parameter int Dbits = 32
);
    logic             mem_wr;
    logic [31:0]      mem_addr;
    logic [Dbits-1:0] mem_writedata;
    logic [Dbits-1:0] mem_readdata;

    modport master (output mem_wr, output mem_addr, output mem_writedata, input mem_readdata);
    modport slave  (input mem_wr, input mem_addr, input mem_writedata, output mem_readdata);
endinterface

// File: rtl/mem_io_responder_key_fifo.sv
// Keyboard receive FIFO with an asynchronous head read.
// A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module key_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     drop
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [PW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign drop    = push & full & ~do_pop;
    assign dout    = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_push && !do_pop) count_d = count_q + 1'b1;
        else if (do_pop && !do_push) count_d = count_q - 1'b1;
    end

    // Storage is deliberately left out of reset; only the bookkeeping is cleared.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

// File: rtl/mem_io_responder.sv
// Data-port responder for the single-cycle core: word RAM plus four memory-mapped I/O registers.
// Reads are combinational; every state change lands on the rising clock edge.
module mem_io_responder
    import memio_pkg::*;
#(
    parameter int Dbits  = 32,
    parameter int Nloc   = 64,
    parameter int Fdepth = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    mem_io_if.slave     bus,
    input  logic        key_valid,
    input  logic [7:0]  key_data,
    output logic        key_ready,
    output logic [15:0] leds
);
    localparam int AW = $clog2(Nloc);
    localparam int CW = $clog2(Fdepth) + 1;

    logic [3:0]       region;
    io_reg_e          io_sel;
    logic [AW-1:0]    ram_idx;
    logic             ram_we, io_we;
    logic             fifo_pop, fifo_full, fifo_empty, fifo_drop;
    logic [7:0]       fifo_dout;
    logic [CW-1:0]    fifo_count;
    logic [Dbits-1:0] ram_mem [Nloc];
    logic [Dbits-1:0] led_q, led_d, cyc_q, cyc_d, rdata;
    logic             ovf_q, ovf_d;
    logic             unused_addr;

    assign region      = bus.mem_addr[31:28];
    assign io_sel      = io_reg_e'(bus.mem_addr[3:2]);
    assign ram_idx     = bus.mem_addr[2 +: AW];
    assign ram_we      = bus.mem_wr & enable & (region == RAM_REGION);
    assign io_we       = bus.mem_wr & enable & (region == IO_REGION);
    assign fifo_pop    = io_we & (io_sel == KEYDATA);
    assign unused_addr = &{1'b0, bus.mem_addr};

    key_fifo #(.DEPTH(Fdepth), .WIDTH(8)) u_key_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (key_valid),
        .pop   (fifo_pop),
        .din   (key_data),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty),
        .drop  (fifo_drop)
    );

    assign key_ready = ~fifo_full;
    assign leds      = led_q[15:0];

    always_ff @(posedge clk) begin
        if (ram_we) ram_mem[ram_idx] <= bus.mem_writedata;
    end

    always_comb begin
        led_d = led_q;
        cyc_d = cyc_q;
        ovf_d = ovf_q;
        if (io_we && io_sel == LED) led_d = bus.mem_writedata;
        // A CYCLES write wins over the same-cycle increment.
        if (io_we && io_sel == CYCLES) cyc_d = '0;
        else if (enable)               cyc_d = cyc_q + 1'b1;
        if (io_we && io_sel == KEYSTAT) ovf_d = 1'b0;
        if (fifo_drop)                  ovf_d = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            led_q <= '0;
            cyc_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            led_q <= led_d;
            cyc_q <= cyc_d;
            ovf_q <= ovf_d;
        end
    end

    always_comb begin
        rdata = '0;
        if (region == RAM_REGION) begin
            rdata = ram_mem[ram_idx];
        end else if (region == IO_REGION) begin
            unique case (io_sel)
                KEYDATA: rdata = fifo_empty ? '0 : Dbits'(fifo_dout);
                KEYSTAT: begin
                    rdata[KS_NEMPTY_BIT] = ~fifo_empty;
                    rdata[KS_OVF_BIT]    = ovf_q;
                    rdata[CW-1:0]        = fifo_count;
                end
                LED:     rdata = led_q;
                CYCLES:  rdata = cyc_q;
            endcase
        end
    end

    assign bus.mem_readdata = rdata;
endmodule

// File: tb/tb_mem_io_responder.sv
// Directed bench for mem_io_responder: a queue/array model checked every negedge plus literal expectations.
module tb_mem_io_responder;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic       key_valid = 1'b0;
    logic [7:0] key_data = 8'h00;
    logic       key_ready;
    logic [15:0] leds;

    int errors = 0;
    int checks = 0;

    mem_io_if #(.Dbits(32)) bus ();

    mem_io_responder #(.Dbits(32), .Nloc(64), .Fdepth(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .bus       (bus),
        .key_valid (key_valid),
        .key_data  (key_data),
        .key_ready (key_ready),
        .leds      (leds)
    );

    always #5 clk = ~clk;

    // Behavioural model state
    byte unsigned m_q[$];
    logic [31:0]  m_ram [64];
    bit           m_ram_ok [64];
    logic [31:0]  m_led = 0;
    logic [31:0]  m_cyc = 0;
    bit           m_ovf = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_read(input logic [31:0] addr, output logic [31:0] v, output bit known);
        v = 32'h0;
        known = 1'b1;
        if (addr[31:28] == 4'h1) begin
            known = m_ram_ok[addr[7:2]];
            v = m_ram[addr[7:2]];
        end else if (addr[31:28] == 4'h2) begin
            case (addr[3:2])
                2'd0: v = (m_q.size() > 0) ? {24'h0, m_q[0]} : 32'h0;
                2'd1: begin
                    v[31]  = (m_q.size() != 0);
                    v[30]  = m_ovf;
                    v[3:0] = 4'(m_q.size());
                end
                2'd2: v = m_led;
                default: v = m_cyc;
            endcase
        end
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_q.delete();
            m_led = 0;
            m_cyc = 0;
            m_ovf = 0;
        end else begin
            bit we, io, popped;
            int sb;
            we = bus.mem_wr & enable;
            io = (bus.mem_addr[31:28] == 4'h2);
            sb = m_q.size();
            popped = 0;
            if (we && io && bus.mem_addr[3:2] == 2'd0 && sb > 0) begin
                void'(m_q.pop_front());
                popped = 1;
            end
            if (we && io && bus.mem_addr[3:2] == 2'd1) m_ovf = 0;
            if (key_valid) begin
                if (sb < 8 || popped) m_q.push_back(key_data);
                else m_ovf = 1;
            end
            if (we && bus.mem_addr[31:28] == 4'h1) begin
                m_ram[bus.mem_addr[7:2]] = bus.mem_writedata;
                m_ram_ok[bus.mem_addr[7:2]] = 1;
            end
            if (we && io && bus.mem_addr[3:2] == 2'd2) m_led = bus.mem_writedata;
            if (we && io && bus.mem_addr[3:2] == 2'd3) m_cyc = 0;
            else if (enable) m_cyc = m_cyc + 1;
        end
    end

    always @(negedge clk) begin
        logic [31:0] ev;
        bit known;
        model_read(bus.mem_addr, ev, known);
        if (known) chk("model_rdata", bus.mem_readdata, ev);
        chk("model_leds", {16'h0, leds}, {16'h0, m_led[15:0]});
        chk("model_key_ready", {31'h0, key_ready}, {31'h0, (m_q.size() < 8)});
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input string name, input logic [31:0] addr, input logic [31:0] exp);
        bus.mem_addr = addr;
        #1;
        chk(name, bus.mem_readdata, exp);
        $display("txn read  %s addr=%h data=%h", name, addr, bus.mem_readdata);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        bus.mem_addr = addr;
        bus.mem_writedata = data;
        bus.mem_wr = 1'b1;
        tick();
        bus.mem_wr = 1'b0;
        $display("txn write addr=%h data=%h enable=%0d", addr, data, enable);
    endtask

    initial begin
        bus.mem_wr = 1'b0;
        bus.mem_addr = 32'h0;
        bus.mem_writedata = 32'h0;
        #1 reset = 1'b1;
        repeat (2) tick();
        rd("reset_keystat", 32'h2000_0004, 32'h0);
        chk("reset_leds", {16'h0, leds}, 32'h0);
        chk("reset_key_ready", {31'h0, key_ready}, 32'h1);
        reset = 1'b0;
        enable = 1'b1;

        // RAM store/load and unmapped region
        wr(32'h1000_0004, 32'h1234_5678);
        wr(32'h1000_0008, 32'hDEAD_BEEF);
        rd("ram_load", 32'h1000_0008, 32'hDEAD_BEEF);
        rd("ram_other_word", 32'h1000_0004, 32'h1234_5678);
        rd("unmapped", 32'h3000_0000, 32'h0);

        // Two pushes, then peek and pop
        key_valid = 1'b1; key_data = 8'h41; tick();
        key_data = 8'h42; tick();
        key_valid = 1'b0;
        rd("keystat_two", 32'h2000_0004, 32'h8000_0002);
        rd("keydata_A", 32'h2000_0000, 32'h41);
        wr(32'h2000_0000, 32'hFFFF_FFFF);
        rd("keydata_B", 32'h2000_0000, 32'h42);
        wr(32'h2000_0000, 32'h0);
        rd("keydata_empty", 32'h2000_0000, 32'h0);

        // Overfill: nine pushes into eight slots
        for (int i = 0; i < 9; i++) begin
            key_valid = 1'b1;
            key_data = 8'(8'h60 + i);
            tick();
            if (i == 7) chk("key_ready_full", {31'h0, key_ready}, 32'h0);
        end
        key_valid = 1'b0;
        rd("keystat_overflow", 32'h2000_0004, 32'hC000_0008);
        wr(32'h2000_0004, 32'h0);
        rd("keystat_ovf_cleared", 32'h2000_0004, 32'h8000_0008);

        // Push and pop together while full
        key_valid = 1'b1; key_data = 8'h55;
        wr(32'h2000_0000, 32'h0);
        key_valid = 1'b0;
        rd("keystat_push_pop_full", 32'h2000_0004, 32'h8000_0008);
        for (int i = 0; i < 8; i++) begin
            logic [31:0] ex;
            ex = (i < 7) ? 32'(8'h61 + i) : 32'h55;
            rd("drain_head", 32'h2000_0000, ex);
            wr(32'h2000_0000, 32'h0);
            if (i == 0) chk("key_ready_after_pop", {31'h0, key_ready}, 32'h1);
        end
        rd("keystat_drained", 32'h2000_0004, 32'h0);

        // Cycle counter
        wr(32'h2000_000C, 32'hAAAA_AAAA);
        rd("cycles_cleared", 32'h2000_000C, 32'h0);
        repeat (10) tick();
        rd("cycles_ten", 32'h2000_000C, 32'd10);
        wr(32'h2000_000C, 32'h0);
        tick();
        rd("cycles_one", 32'h2000_000C, 32'd1);
        enable = 1'b0;
        repeat (3) tick();
        rd("cycles_hold", 32'h2000_000C, 32'd1);
        wr(32'h2000_0008, 32'h0000_FFFF);
        chk("led_write_disabled", {16'h0, leds}, 32'h0);

        // LED write, queue three characters, then asynchronous reset
        enable = 1'b1;
        wr(32'h2000_0008, 32'h0001_ABCD);
        chk("leds_abcd", {16'h0, leds}, 32'h0000_ABCD);
        rd("led_readback", 32'h2000_0008, 32'h0001_ABCD);
        for (int i = 0; i < 3; i++) begin
            key_valid = 1'b1;
            key_data = 8'(8'h30 + i);
            tick();
        end
        key_valid = 1'b0;
        rd("keystat_three", 32'h2000_0004, 32'h8000_0003);
        reset = 1'b1;
        #1;
        chk("async_reset_leds", {16'h0, leds}, 32'h0);
        chk("async_reset_key_ready", {31'h0, key_ready}, 32'h1);
        rd("async_reset_keystat", 32'h2000_0004, 32'h0);
        rd("async_reset_cycles", 32'h2000_000C, 32'h0);
        rd("async_reset_keydata", 32'h2000_0000, 32'h0);
        tick();
        reset = 1'b0;
        tick();
        rd("post_reset_keystat", 32'h2000_0004, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
